cam_capture_ctrl: RTL and testbench

Frame-capture sequencer between the OV7670-style camera byte stream and the frame-buffer write port. It arms on request and synchronises to VSYNC. It pairs YCbCr 4:2:2 bytes into 16-bit words, generates frame-buffer write strobes and linear addresses, and reports frame completion and line/frame length errors. Single-shot and continuous capture are supported, with a clean stop at the frame boundary.

---
 rtl/cam_capture_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_ctrl.sv
// Camera byte-stream capture sequencer.
// Pairs bytes into words and drives frame-buffer writes.
module cam_capture_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        byte_camera,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       pixel_data,
  output logic [9:0]        line_idx,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              err_line_len,
  output logic              err_frame_len
);

  // col saturates one past H_ACTIVE so long lines stay detectable
  localparam int COL_W = $clog2(H_ACTIVE + 2);
  localparam logic [COL_W-1:0] COL_END = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] COL_SAT = COL_W'(H_ACTIVE + 1);
  localparam logic [9:0] LAST_LINE = 10'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SYNC,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic              vsync_d;
  logic              href_d;
  logic              vs_rise;
  logic              href_fall;
  logic              phase;
  logic [7:0]        hi_byte;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] line_base;
  logic              stop_pending;
  logic              in_active;
  logic              word_in;
  logic              line_end;
  logic              last_line;
  logic              take_start;

  assign vs_rise    = vsync & ~vsync_d;
  assign href_fall  = href_d & ~href;
  assign in_active  = (state == S_ACTIVE);
  assign word_in    = in_active & ~vs_rise & href & phase;
  assign line_end   = in_active & ~vs_rise & href_fall;
  assign last_line  = (line_idx == LAST_LINE);
  assign take_start = (state == S_IDLE) & start;

  // State register
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_ARMED;
      S_ARMED: begin
        if (stop)         state_nx = S_IDLE;
        else if (vs_rise) state_nx = S_SYNC;
      end
      S_SYNC: begin
        if (stop)        state_nx = S_IDLE;
        else if (!vsync) state_nx = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (vs_rise)
          state_nx = S_SYNC;
        else if (line_end && last_line)
          state_nx = S_DONE;
      end
      S_DONE: begin
        if (continuous && !stop_pending && !stop)
          state_nx = S_ARMED;
        else
          state_nx = S_IDLE;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (1'b1)
      (state == S_IDLE): busy       = 1'b0;
      (state == S_DONE): frame_done = 1'b1;
      default: ;
    endcase
  end

  // Input delay registers for edge detection
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_d <= vsync;
      href_d  <= href;
    end
  end

  // Byte pairing; a half word is dropped outside ACTIVE
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      phase   <= 1'b0;
      hi_byte <= '0;
    end else begin
      if (!in_active || line_end) phase <= 1'b0;
      else if (href)              phase <= ~phase;
      if (in_active && href && !phase)
        hi_byte <= byte_camera;
    end
  end

  // Column, row base and line counters
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      line_base <= '0;
      line_idx  <= '0;
    end else if (state == S_SYNC) begin
      col       <= '0;
      line_base <= '0;
      line_idx  <= '0;
    end else if (line_end) begin
      col       <= '0;
      line_base <= line_base + ADDR_W'(H_ACTIVE);
      line_idx  <= line_idx + 10'd1;
    end else if (word_in && col != COL_SAT) begin
      col <= col + 1'b1;
    end
  end

  // Registered frame-buffer write port
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      pixel_data <= '0;
    end else begin
      wr_en <= word_in && (col < COL_END);
      if (word_in && (col < COL_END)) begin
        wr_addr    <= line_base + ADDR_W'(col);
        pixel_data <= {hi_byte, byte_camera};
      end
    end
  end

  // Completed-frame counter
  always_ff @(posedge pclk or posedge reset) begin
    if (reset)                frame_count <= '0;
    else if (state == S_DONE) frame_count <= frame_count + 8'd1;
  end

  // Sticky errors and deferred stop
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      err_line_len  <= 1'b0;
      err_frame_len <= 1'b0;
      stop_pending  <= 1'b0;
    end else if (take_start) begin
      err_line_len  <= 1'b0;
      err_frame_len <= 1'b0;
      stop_pending  <= 1'b0;
    end else begin
      if (line_end && (col != COL_END || phase))
        err_line_len <= 1'b1;
      if (in_active && vs_rise)
        err_frame_len <= 1'b1;
      if (in_active && stop)
        stop_pending <= 1'b1;
      else if (state == S_DONE)
        stop_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl.
// Small 4x3 frame geometry.
module tb_cam_capture_ctrl;

  localparam int H = 4;
  localparam int V = 3;
  localparam int AW = 4;

  logic          pclk = 1'b0;
  logic          reset = 1'b1;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    byte_camera = '0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          stop = 1'b0;
  logic          busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   pixel_data;
  logic [9:0]    line_idx;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic          err_line_len;
  logic          err_frame_len;

  int total = 0;
  int bad = 0;
  int fd_cnt = 0;
  int wr_cnt = 0;
  logic [15:0] written = '0;

  cam_capture_ctrl #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .ADDR_W(AW)
  ) dut (
    .pclk(pclk),
    .reset(reset),
    .vsync(vsync),
    .href(href),
    .byte_camera(byte_camera),
    .start(start),
    .continuous(continuous),
    .stop(stop),
    .busy(busy),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .pixel_data(pixel_data),
    .line_idx(line_idx),
    .frame_done(frame_done),
    .frame_count(frame_count),
    .err_line_len(err_line_len),
    .err_frame_len(err_frame_len)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          n0;
    int          n1;
    int          n2;
    logic [15:0] mask;
    logic        eline;
    int          fc;
  } vec_t;

  vec_t vt[3];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic line(int n);
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      byte_camera = 8'(i);
      tick();
    end
    href = 1'b0;
    byte_camera = '0;
    repeat (3) tick();
  endtask

  // Word at row column c always carries bytes 2c, 2c+1
  always @(negedge pclk) begin
    int c;
    logic [15:0] exp_pd;
    if (frame_done) fd_cnt++;
    if (wr_en) begin
      wr_cnt++;
      written[wr_addr] = 1'b1;
      c = int'(wr_addr) % H;
      exp_pd = {8'(2 * c), 8'(2 * c + 1)};
      chk("wr_data", 32'(pixel_data), 32'(exp_pd));
    end
  end

  initial begin
    int fd0;
    int wc0;

    vt[0] = '{n0: 8, n1: 8, n2: 8, mask: 16'h0FFF,
              eline: 1'b0, fc: 1};
    vt[1] = '{n0: 8, n1: 6, n2: 8, mask: 16'h0F7F,
              eline: 1'b1, fc: 2};
    vt[2] = '{n0: 10, n1: 8, n2: 8, mask: 16'h0FFF,
              eline: 1'b1, fc: 3};

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_fcount", 32'(frame_count), 0);
    chk("rst_errs", 32'({err_line_len, err_frame_len}), 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    for (int i = 0; i < 3; i++) begin
      continuous = 1'b0;
      written = '0;
      fd0 = fd_cnt;
      pulse_start();
      chk("armed_busy", 32'(busy), 1);
      vs_pulse();
      line(vt[i].n0);
      line(vt[i].n1);
      line(vt[i].n2);
      repeat (3) tick();
      chk($sformatf("v%0d_mask", i), 32'(written),
          32'(vt[i].mask));
      chk($sformatf("v%0d_eline", i), 32'(err_line_len),
          32'(vt[i].eline));
      chk($sformatf("v%0d_eframe", i), 32'(err_frame_len), 0);
      chk($sformatf("v%0d_fdone", i), fd_cnt - fd0, 1);
      chk($sformatf("v%0d_fcount", i), 32'(frame_count),
          32'(vt[i].fc));
      chk($sformatf("v%0d_busy", i), 32'(busy), 0);
    end

    // Early VSYNC aborts, then the same pulse starts a frame
    written = '0;
    fd0 = fd_cnt;
    pulse_start();
    chk("abort_eline_clr", 32'(err_line_len), 0);
    vs_pulse();
    line(8);
    line(8);
    chk("abort_line_idx", 32'(line_idx), 2);
    vs_pulse();
    chk("abort_eframe", 32'(err_frame_len), 1);
    chk("abort_no_fdone", fd_cnt - fd0, 0);
    chk("abort_fcount", 32'(frame_count), 3);
    written = '0;
    line(8);
    line(8);
    line(8);
    repeat (3) tick();
    chk("refr_mask", 32'(written), 32'h0FFF);
    chk("refr_fdone", fd_cnt - fd0, 1);
    chk("refr_fcount", 32'(frame_count), 4);
    chk("refr_eline", 32'(err_line_len), 0);

    // Continuous with a mid-frame stop
    continuous = 1'b1;
    fd0 = fd_cnt;
    pulse_start();
    chk("cont_eframe_clr", 32'(err_frame_len), 0);
    vs_pulse();
    line(8);
    line(8);
    line(8);
    repeat (2) tick();
    chk("cont_rearm_busy", 32'(busy), 1);
    written = '0;
    vs_pulse();
    line(8);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("cont_stop_busy", 32'(busy), 1);
    line(8);
    line(8);
    repeat (3) tick();
    chk("cont_f2_mask", 32'(written), 32'h0FFF);
    chk("cont_fdone", fd_cnt - fd0, 2);
    chk("cont_fcount", 32'(frame_count), 6);
    chk("cont_idle", 32'(busy), 0);
    wc0 = wr_cnt;
    vs_pulse();
    line(8);
    chk("cont_after_wr", wr_cnt - wc0, 0);
    chk("cont_after_busy", 32'(busy), 0);

    // Asynchronous reset mid-line
    continuous = 1'b0;
    pulse_start();
    vs_pulse();
    href = 1'b1;
    byte_camera = 8'd0;
    tick();
    byte_camera = 8'd1;
    tick();
    chk("pre_rst_wr_en", 32'(wr_en), 1);
    chk("pre_rst_fcount", 32'(frame_count), 6);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_wr_en", 32'(wr_en), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_fcount", 32'(frame_count), 0);
    chk("arst_line_idx", 32'(line_idx), 0);
    chk("arst_addr", 32'(wr_addr), 0);
    chk("arst_data", 32'(pixel_data), 0);
    href = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    wc0 = wr_cnt;
    vs_pulse();
    line(8);
    line(8);
    chk("post_rst_wr", wr_cnt - wc0, 0);
    chk("post_rst_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
